// File: rtl/call_stack.sv
// -----------------------------------------------------------------------------
// call_stack
//   Hardware return-address stack feeding the RET operand of the writeback
//   result mux. CALL pushes PC+PC_INC, RETURN pops. The top entry is presented
//   combinationally on RET so it is usable in the same cycle RETURN is decoded.
//
// Parameters
//   WIDTH   address/data width of each entry
//   DEPTH   number of entries (power of two, >= 2)
//   PC_INC  added to PC to form the pushed return address (mod 2^WIDTH)
//
// Ports
//   clk     in   1              clock, rising edge
//   rst     in   1              asynchronous, active-high reset
//   Stall   in   1              1 = freeze all state; CALL/RETURN ignored
//   CALL    in   1              push PC+PC_INC at this edge
//   RETURN  in   1              pop top entry at this edge
//   PC      in   WIDTH          current instruction address
//   RET     out  WIDTH          top-of-stack value, 0 when empty
//   Count   out  log2(DEPTH)+1  entries held, 0..DEPTH
//   Empty   out  1              Count == 0
//   Full    out  1              Count == DEPTH
//   Ovf     out  1              sticky: push attempted while full
//   Unf     out  1              sticky: pop attempted while empty
//
// Configuration macro
//   CALL_STACK_WRAP_EN  defined: push while full overwrites the oldest entry
//                       (circular storage, newest DEPTH addresses kept).
//                       undefined: push while full is dropped.
//                       Ovf is set in both cases.
// -----------------------------------------------------------------------------
module call_stack #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int PC_INC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Stall,
    input  logic                       CALL,
    input  logic                       RETURN,
    input  logic [WIDTH-1:0]           PC,
    output logic [WIDTH-1:0]           RET,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Ovf,
    output logic                       Unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // r_ptr addresses the next free slot; the top entry lives at r_ptr-1.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_push_val;
    logic [PW-1:0]    w_top_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_en;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_ptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;

    assign w_push_val = PC + WIDTH'(PC_INC);
    assign w_top_idx  = r_ptr - PW'(1);
    assign w_empty    = (r_count == CW'(0));
    assign w_full     = (r_count == CW'(DEPTH));

    // Read side: combinational view of the stack state.
    assign RET   = w_empty ? {WIDTH{1'b0}} : r_mem[w_top_idx];
    assign Count = r_count;
    assign Empty = w_empty;
    assign Full  = w_full;
    assign Ovf   = r_ovf;
    assign Unf   = r_unf;

    // Next-state decode of CALL/RETURN against the current occupancy.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = r_ptr;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        if (Stall) begin
            w_wr_en = 1'b0;
        end else if (CALL && RETURN && !w_empty) begin
            // Simultaneous return+call replaces the top entry in place.
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
        end else if (CALL) begin
            // CALL&RETURN on an empty stack also lands here: a plain push.
            if (!w_full) begin
                w_wr_en     = 1'b1;
                w_ptr_nxt   = r_ptr + PW'(1);
                w_count_nxt = r_count + CW'(1);
            end else begin
                w_ovf_nxt = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                // Full and circular: r_ptr equals the oldest slot, overwrite it.
                w_wr_en   = 1'b1;
                w_ptr_nxt = r_ptr + PW'(1);
`else
                w_wr_en   = 1'b0;
`endif
            end
        end else if (RETURN) begin
            if (!w_empty) begin
                w_ptr_nxt   = r_ptr - PW'(1);
                w_count_nxt = r_count - CW'(1);
            end else begin
                w_unf_nxt = 1'b1;
            end
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Pointer, occupancy and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Entry storage; cleared on reset, written on push/overwrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_push_val;
        end else begin
            r_mem[w_wr_idx] <= r_mem[w_wr_idx];
        end
    end

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        CALL;
    logic        RETURN;
    logic [31:0] PC;
    logic [31:0] RET;
    logic [4:0]  Count;
    logic        Empty;
    logic        Full;
    logic        Ovf;
    logic        Unf;

    int n_checks = 0;
    int n_errors = 0;

    call_stack #(.WIDTH(32), .DEPTH(16), .PC_INC(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .Stall  (Stall),
        .CALL   (CALL),
        .RETURN (RETURN),
        .PC     (PC),
        .RET    (RET),
        .Count  (Count),
        .Empty  (Empty),
        .Full   (Full),
        .Ovf    (Ovf),
        .Unf    (Unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        call;
        logic        ret;
        logic [31:0] pc;
        logic [31:0] e_ret;
        logic [4:0]  e_count;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_ret, input logic [4:0] e_cnt,
                             input logic e_empty, input logic e_full, input logic e_ovf,
                             input logic e_unf);
        check({tag, ".RET"},   RET,          e_ret);
        check({tag, ".Count"}, 32'(Count),   32'(e_cnt));
        check({tag, ".Empty"}, 32'(Empty),   32'(e_empty));
        check({tag, ".Full"},  32'(Full),    32'(e_full));
        check({tag, ".Ovf"},   32'(Ovf),     32'(e_ovf));
        check({tag, ".Unf"},   32'(Unf),     32'(e_unf));
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, sample 1 ns later.
    task automatic step(input logic s, input logic c, input logic r, input logic [31:0] pc);
        @(negedge clk);
        Stall  = s;
        CALL   = c;
        RETURN = r;
        PC     = pc;
        @(posedge clk);
        #1;
        Stall  = 1'b0;
        CALL   = 1'b0;
        RETURN = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        Stall  = 1'b0;
        CALL   = 1'b0;
        RETURN = 1'b0;
        PC     = 32'h0;

        //           stall call  ret   pc            RET          cnt   emp   full  ovf   unf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h00000100, 32'h00000104, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00000200, 32'h00000204, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h00000300, 32'h00000304, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000204, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000104, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h00000800, 32'h00000804, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00000100, 32'h00000104, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h00000500, 32'h00000504, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h00000700, 32'h00000504, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000504, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000804, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};

        #3;
        check_all("reset", 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].stall, vecs[i].call, vecs[i].ret, vecs[i].pc);
            check_all($sformatf("vec%0d", i), vecs[i].e_ret, vecs[i].e_count,
                      vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // RET seen during the RETURN cycle is the pre-pop top.
        @(negedge clk);
        RETURN = 1'b1;
        #1;
        check("prepop.RET", RET, 32'h00000804);
        @(posedge clk);
        #1;
        RETURN = 1'b0;
        check("postpop.Count", 32'(Count), 32'd0);

        // Asynchronous reset mid-cycle after three pushes.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h00000100);
        step(1'b0, 1'b1, 1'b0, 32'h00000200);
        step(1'b0, 1'b1, 1'b0, 32'h00000300);
        step(1'b0, 1'b0, 1'b1, 32'h00000000);
        step(1'b0, 1'b0, 1'b1, 32'h00000000);
        step(1'b0, 1'b0, 1'b1, 32'h00000000);
        step(1'b0, 1'b0, 1'b1, 32'h00000000);
        step(1'b0, 1'b1, 1'b0, 32'h00000100);
        step(1'b0, 1'b1, 1'b0, 32'h00000200);
        step(1'b0, 1'b1, 1'b0, 32'h00000300);
        check_all("pre_rst", 32'h00000304, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Entries must be gone: a push/pop pair re-exposes nothing stale.
        step(1'b0, 1'b1, 1'b0, 32'h00000040);
        step(1'b0, 1'b0, 1'b1, 32'h00000000);
        check_all("after_rst", 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Overflow: 17 calls at PC = 0x10*i.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(16 * i));
        end
        check_all("full16", 32'h000000F4, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h00000100);
`ifdef CALL_STACK_WRAP_EN
        check_all("ovf17", 32'h00000104, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
`else
        check_all("ovf17", 32'h000000F4, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        for (int k = 0; k < 16; k++) begin
            logic [31:0] exp_top;
`ifdef CALL_STACK_WRAP_EN
            exp_top = 32'h00000104 - 32'(16 * k);
`else
            exp_top = 32'h000000F4 - 32'(16 * k);
`endif
            @(negedge clk);
            RETURN = 1'b1;
            #1;
            check($sformatf("drain%0d.RET", k), RET, exp_top);
            @(posedge clk);
            #1;
            RETURN = 1'b0;
        end
        check_all("drained", 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Push value wraps modulo 2^32.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'hFFFFFFFC);
        check_all("pc_wrap", 32'h00000000, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
